// File: rtl/hash_probe_if.sv
// hash_probe_if
//   Bundles every signal between the dictionary probe controller and its
//   surroundings: the lookup request/response handshake from the core FSM,
//   the single-port dictionary RAM port, and the conflict-table write port.
//
//   Modports:
//     slave  - the probe controller (hash_probe_ctrl).
//     master - the environment around it (core FSM, dictionary RAM and
//              conflict table). It drives the request, rsp_ready, the RAM
//              read data and ct_full.
//
//   Signal groups:
//     req_*  lookup request (valid/ready, home hash, string, insert flag)
//     rsp_*  lookup result (valid/ready, hit/inserted/fail, slot, map, probes)
//     ram_*  dictionary RAM command, write data and read data
//     ct_*   conflict-table full flag and write strobe/address
interface hash_probe_if #(
   parameter int HASH_WIDTH = 11,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_PROBES = 16
);
   localparam int PROBE_WIDTH = $clog2(MAX_PROBES + 1);

   logic                   req_valid;
   logic                   req_ready;
   logic [HASH_WIDTH-1:0]  req_hash;
   logic [DATA_WIDTH-1:0]  req_str;
   logic                   req_insert;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic                   rsp_hit;
   logic                   rsp_inserted;
   logic                   rsp_fail;
   logic [HASH_WIDTH-1:0]  rsp_addr;
   logic [HASH_WIDTH-1:0]  rsp_map;
   logic [PROBE_WIDTH-1:0] rsp_probes;

   logic                   ram_cs;
   logic                   ram_we;
   logic [HASH_WIDTH-1:0]  ram_addr;
   logic [DATA_WIDTH-1:0]  ram_wdata;
   logic [DATA_WIDTH-1:0]  ram_rdata;
   logic                   ram_rvalid;
   logic [HASH_WIDTH-1:0]  ram_map;

   logic                   ct_full;
   logic                   ct_we;
   logic [HASH_WIDTH-1:0]  ct_addr;

   modport master (
      output req_valid, req_hash, req_str, req_insert, rsp_ready,
             ram_rdata, ram_rvalid, ram_map, ct_full,
      input  req_ready, rsp_valid, rsp_hit, rsp_inserted, rsp_fail,
             rsp_addr, rsp_map, rsp_probes,
             ram_cs, ram_we, ram_addr, ram_wdata, ct_we, ct_addr
   );

   modport slave (
      input  req_valid, req_hash, req_str, req_insert, rsp_ready,
             ram_rdata, ram_rvalid, ram_map, ct_full,
      output req_ready, rsp_valid, rsp_hit, rsp_inserted, rsp_fail,
             rsp_addr, rsp_map, rsp_probes,
             ram_cs, ram_we, ram_addr, ram_wdata, ct_we, ct_addr
   );
endinterface

// File: rtl/hash_probe_ctrl.sv
// hash_probe_ctrl
//   Runs one LZW dictionary lookup against a single-port RAM. The home hash
//   slot is read first; on a collision the controller probes linearly,
//   wrapping from the top slot back to MIN_ADDR. A miss with insert requested
//   writes the string into the first free slot, and when that slot is not the
//   home slot a conflict-table write is strobed so the core can find it later.
//   Codes below MIN_ADDR are single-byte strings and answer immediately.
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset; aborts any lookup in flight
//     bus  hash_probe_if.slave: request/response handshake, RAM port and
//          conflict-table port
//
//   Response outputs are forced to zero outside the response state, so the
//   captured string/address registers need no reset of their own.
module hash_probe_ctrl #(
   parameter int HASH_WIDTH = 11,
   parameter int DATA_WIDTH = 64,
   parameter int MIN_ADDR   = 256,
   parameter int MAX_PROBES = 16,
   parameter int RD_LAT     = 1
) (
   input  logic         clk,
   input  logic         rst,
   hash_probe_if.slave  bus
);
   localparam int PW        = $clog2(MAX_PROBES + 1);
   localparam int WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;
   localparam int WW        = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

   localparam logic [HASH_WIDTH-1:0] MIN_SLOT  = HASH_WIDTH'(MIN_ADDR);
   localparam logic [HASH_WIDTH-1:0] TOP_SLOT  = {HASH_WIDTH{1'b1}};
   localparam logic [PW-1:0]         PROBE_MAX = PW'(MAX_PROBES);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ISSUE, ST_WAIT, ST_CHECK, ST_WRITE, ST_RESP
   } state_t;

   // Linear probe step; slots below MIN_SLOT are never probed.
   function automatic logic [HASH_WIDTH-1:0] next_slot(input logic [HASH_WIDTH-1:0] slot);
      if (slot == TOP_SLOT) return MIN_SLOT;
      return slot + 1'b1;
   endfunction

   state_t                state, state_n;
   logic [WW-1:0]         wait_cnt, wait_cnt_n;
   logic [PW-1:0]         probes, probes_n;
   logic                  hit, hit_n;
   logic                  inserted, inserted_n;
   logic                  fail, fail_n;

   logic [HASH_WIDTH-1:0] home, home_n;
   logic [HASH_WIDTH-1:0] cur, cur_n;
   logic [DATA_WIDTH-1:0] str, str_n;
   logic                  ins_req, ins_req_n;
   logic [HASH_WIDTH-1:0] addr_r, addr_n;
   logic [HASH_WIDTH-1:0] map_r, map_n;

   logic in_resp;
   logic in_write;
   logic away;
   logic match;

   assign in_resp  = (state == ST_RESP);
   assign in_write = (state == ST_WRITE);
   assign away     = (cur != home);
   assign match    = bus.ram_rvalid && (bus.ram_rdata == str);

   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      probes_n   = probes;
      hit_n      = hit;
      inserted_n = inserted;
      fail_n     = fail;
      home_n     = home;
      cur_n      = cur;
      str_n      = str;
      ins_req_n  = ins_req;
      addr_n     = addr_r;
      map_n      = map_r;

      case (state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               home_n     = bus.req_hash;
               cur_n      = bus.req_hash;
               str_n      = bus.req_str;
               ins_req_n  = bus.req_insert;
               probes_n   = '0;
               hit_n      = 1'b0;
               inserted_n = 1'b0;
               fail_n     = 1'b0;
               addr_n     = bus.req_hash;
               map_n      = '0;
               if (bus.req_hash < MIN_SLOT) begin
                  // Single-byte code: its own slot and map value.
                  hit_n   = 1'b1;
                  map_n   = bus.req_hash;
                  state_n = ST_RESP;
               end else begin
                  state_n = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
            probes_n = probes + 1'b1;
            if (RD_LAT > 1) begin
               wait_cnt_n = WW'(WAIT_INIT);
               state_n    = ST_WAIT;
            end else begin
               state_n = ST_CHECK;
            end
         end

         ST_WAIT: begin
            if (wait_cnt == '0) state_n = ST_CHECK;
            else                wait_cnt_n = wait_cnt - 1'b1;
         end

         ST_CHECK: begin
            if (match) begin
               hit_n   = 1'b1;
               addr_n  = cur;
               map_n   = bus.ram_map;
               state_n = ST_RESP;
            end else if (!bus.ram_rvalid && !ins_req) begin
               addr_n  = cur;
               state_n = ST_RESP;
            end else if (!bus.ram_rvalid && away && bus.ct_full) begin
               // An off-home insert needs a conflict-table entry; none left.
               fail_n  = 1'b1;
               addr_n  = cur;
               state_n = ST_RESP;
            end else if (!bus.ram_rvalid) begin
               state_n = ST_WRITE;
            end else if (probes == PROBE_MAX) begin
               fail_n  = 1'b1;
               addr_n  = home;
               state_n = ST_RESP;
            end else begin
               cur_n   = next_slot(cur);
               state_n = ST_ISSUE;
            end
         end

         ST_WRITE: begin
            inserted_n = 1'b1;
            addr_n     = cur;
            state_n    = ST_RESP;
         end

         ST_RESP: begin
            if (bus.rsp_ready) state_n = ST_IDLE;
         end

         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         probes   <= '0;
         hit      <= 1'b0;
         inserted <= 1'b0;
         fail     <= 1'b0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
         probes   <= probes_n;
         hit      <= hit_n;
         inserted <= inserted_n;
         fail     <= fail_n;
      end
   end

   always_ff @(posedge clk) begin
      home    <= home_n;
      cur     <= cur_n;
      str     <= str_n;
      ins_req <= ins_req_n;
      addr_r  <= addr_n;
      map_r   <= map_n;
   end

   assign bus.req_ready    = (state == ST_IDLE);
   assign bus.rsp_valid    = in_resp;
   assign bus.rsp_hit      = in_resp && hit;
   assign bus.rsp_inserted = in_resp && inserted;
   assign bus.rsp_fail     = in_resp && fail;
   assign bus.rsp_addr     = in_resp ? addr_r : '0;
   assign bus.rsp_map      = in_resp ? map_r  : '0;
   assign bus.rsp_probes   = in_resp ? probes : '0;

   assign bus.ram_cs    = (state == ST_ISSUE) || in_write;
   assign bus.ram_we    = in_write;
   assign bus.ram_addr  = bus.ram_cs ? cur : '0;
   assign bus.ram_wdata = in_write ? str : '0;

   assign bus.ct_we   = in_write && away;
   assign bus.ct_addr = (in_write && away) ? cur : '0;
endmodule

// File: tb/tb_hash_probe_ctrl.sv
module tb_hash_probe_ctrl;
   localparam int HW    = 11;
   localparam int DW    = 64;
   localparam int MINA  = 256;
   localparam int MAXP  = 4;
   localparam int RDL   = 2;
   localparam int PW    = $clog2(MAXP + 1);
   localparam int DEPTH = 1 << HW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hash_probe_if #(.HASH_WIDTH(HW), .DATA_WIDTH(DW), .MAX_PROBES(MAXP)) bus ();

   hash_probe_ctrl #(
      .HASH_WIDTH(HW), .DATA_WIDTH(DW), .MIN_ADDR(MINA), .MAX_PROBES(MAXP), .RD_LAT(RDL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   // Dictionary contents, owned by the stimulus process.
   logic [DW-1:0] mem_data  [DEPTH];
   logic          mem_valid [DEPTH];
   logic [HW-1:0] mem_map   [DEPTH];

   // RAM with RD_LAT cycles of read latency.
   logic [DW-1:0] pipe_data  [RDL];
   logic          pipe_valid [RDL];
   logic [HW-1:0] pipe_map   [RDL];
   always @(posedge clk) begin
      pipe_data[0]  <= mem_data[bus.ram_addr];
      pipe_valid[0] <= mem_valid[bus.ram_addr];
      pipe_map[0]   <= mem_map[bus.ram_addr];
      for (int i = 1; i < RDL; i++) begin
         pipe_data[i]  <= pipe_data[i-1];
         pipe_valid[i] <= pipe_valid[i-1];
         pipe_map[i]   <= pipe_map[i-1];
      end
   end
   assign bus.ram_rdata  = pipe_data[RDL-1];
   assign bus.ram_rvalid = pipe_valid[RDL-1];
   assign bus.ram_map    = pipe_map[RDL-1];

   // Bus monitor: logs every RAM read, RAM write and conflict-table write.
   int rd_n = 0, wr_n = 0, ct_n = 0, cs_n = 0;
   logic [HW-1:0] rd_log [1024];
   logic [HW-1:0] wr_a_log [1024];
   logic [DW-1:0] wr_d_log [1024];
   logic [HW-1:0] ct_log [1024];
   always @(posedge clk) begin
      if (bus.ram_cs) cs_n <= cs_n + 1;
      if (bus.ram_cs && !bus.ram_we) begin
         rd_log[rd_n[9:0]] <= bus.ram_addr;
         rd_n <= rd_n + 1;
      end
      if (bus.ram_cs && bus.ram_we) begin
         wr_a_log[wr_n[9:0]] <= bus.ram_addr;
         wr_d_log[wr_n[9:0]] <= bus.ram_wdata;
         wr_n <= wr_n + 1;
      end
      if (bus.ct_we) begin
         ct_log[ct_n[9:0]] <= bus.ct_addr;
         ct_n <= ct_n + 1;
      end
   end

   int n_tests, n_fail;

   // Observed response of the last request.
   logic          o_timeout, o_ready0;
   logic [2:0]    o_flags;
   logic [HW-1:0] o_addr, o_map;
   logic [PW-1:0] o_probes;
   logic [1:0]    o_after;
   int            o_lat, o_unstable;
   int            base_rd, base_wr, base_ct, base_cs;

   // Reference model outputs.
   logic [2:0]    e_flags;
   logic [HW-1:0] e_addr, e_map;
   logic [HW-1:0] e_rd [MAXP];
   logic          e_addr_chk, e_ct;
   int            e_probes, e_lat;

   // Behavioural lookup: walk the table as the dictionary rules describe.
   task automatic model(input logic [HW-1:0] h, input logic [DW-1:0] s,
                        input logic ins, input logic ctf);
      logic [HW-1:0] a;
      e_flags = 3'b000; e_addr = h; e_map = '0; e_addr_chk = 1'b1;
      e_ct = 1'b0; e_probes = 0;
      if (int'(h) < MINA) begin
         e_flags = 3'b100; e_map = h; e_lat = 1;
         return;
      end
      a = h;
      for (int n = 1; n <= MAXP; n++) begin
         e_rd[n-1] = a;
         e_probes  = n;
         if (mem_valid[a] && mem_data[a] == s) begin
            e_flags = 3'b100; e_addr = a; e_map = mem_map[a];
            break;
         end
         if (!mem_valid[a]) begin
            if (!ins) begin
               e_addr = a;
            end else if (a != h && ctf) begin
               e_flags = 3'b001; e_addr_chk = 1'b0;
            end else begin
               e_flags = 3'b010; e_addr = a; e_ct = (a != h);
            end
            break;
         end
         if (n == MAXP) begin
            e_flags = 3'b001; e_addr = h;
            break;
         end
         a = (int'(a) == DEPTH - 1) ? HW'(MINA) : a + 11'd1;
      end
      e_lat = e_probes * (RDL + 1) + 1 + (e_flags[1] ? 1 : 0);
   endtask

   // Drives one request, holds rsp_ready low for 'stall' cycles, then accepts.
   task automatic do_req(input logic [HW-1:0] h, input logic [DW-1:0] s,
                         input logic ins, input logic ctf, input int stall);
      logic [3+2*HW+PW-1:0] snap;
      @(negedge clk);
      base_rd = rd_n; base_wr = wr_n; base_ct = ct_n; base_cs = cs_n;
      bus.req_valid = 1'b1; bus.req_hash = h; bus.req_str = s;
      bus.req_insert = ins; bus.ct_full = ctf;
      o_ready0 = bus.req_ready;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      o_lat = 1;
      while (!bus.rsp_valid && o_lat < 200) begin
         @(negedge clk);
         o_lat++;
      end
      o_timeout = !bus.rsp_valid;
      o_flags   = {bus.rsp_hit, bus.rsp_inserted, bus.rsp_fail};
      o_addr    = bus.rsp_addr;
      o_map     = bus.rsp_map;
      o_probes  = bus.rsp_probes;
      snap      = {o_flags, o_addr, o_map, o_probes};
      o_unstable = 0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if ({bus.rsp_hit, bus.rsp_inserted, bus.rsp_fail, bus.rsp_addr, bus.rsp_map,
              bus.rsp_probes} !== snap || bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0)
            o_unstable++;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.ct_full   = 1'b0;
      o_after = {bus.rsp_valid, bus.req_ready};
      if (o_timeout) begin
         rst = 1'b1;
         @(posedge clk);
         @(negedge clk);
         rst = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_inserted, bus.rsp_fail,
           bus.ram_cs, bus.ram_we, bus.ct_we} !== 8'b1000_0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 10000000", {bus.req_ready, bus.rsp_valid,
                  bus.rsp_hit, bus.rsp_inserted, bus.rsp_fail, bus.ram_cs, bus.ram_we, bus.ct_we});
      end
      n_tests++;
      if ({bus.rsp_addr, bus.rsp_map, bus.rsp_probes, bus.ram_addr, bus.ram_wdata, bus.ct_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got addr=%h map=%h probes=%0d ram_addr=%h wdata=%h ct_addr=%h want all 0",
                  bus.rsp_addr, bus.rsp_map, bus.rsp_probes, bus.ram_addr, bus.ram_wdata, bus.ct_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_direct;
      do_req(11'h041, 64'hA5A5_0000_0000_0041, 1'b1, 1'b0, 0);
      n_tests++;
      if (o_timeout !== 1'b0 || o_flags !== 3'b100) begin
         n_fail++; $display("FAIL direct_flags: got timeout=%b flags=%b want 0/100", o_timeout, o_flags);
      end
      n_tests++;
      if (o_addr !== 11'h041 || o_map !== 11'h041 || o_probes !== '0) begin
         n_fail++; $display("FAIL direct_result: got addr=%h map=%h probes=%0d want 041/041/0", o_addr, o_map, o_probes);
      end
      n_tests++;
      if (o_lat != 1 || cs_n != base_cs) begin
         n_fail++; $display("FAIL direct_timing: got lat=%0d ram_cs=%0d want 1/0", o_lat, cs_n - base_cs);
      end
   endtask

   task automatic test_hit;
      mem_valid[11'h300] = 1'b1; mem_data[11'h300] = 64'h0123_4567_89AB_CDEF; mem_map[11'h300] = 11'h123;
      do_req(11'h300, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 0);
      n_tests++;
      if (o_flags !== 3'b100 || o_addr !== 11'h300 || o_map !== 11'h123 || o_probes !== 3'd1) begin
         n_fail++; $display("FAIL hit_result: got flags=%b addr=%h map=%h probes=%0d want 100/300/123/1",
                            o_flags, o_addr, o_map, o_probes);
      end
      n_tests++;
      if (o_lat != RDL + 2 || rd_n - base_rd != 1 || rd_log[base_rd[9:0]] !== 11'h300) begin
         n_fail++; $display("FAIL hit_timing: got lat=%0d reads=%0d want %0d/1", o_lat, rd_n - base_rd, RDL + 2);
      end
   endtask

   task automatic test_insert_home;
      mem_valid[11'h300] = 1'b0;
      do_req(11'h300, 64'hFEED_0000_0000_0300, 1'b1, 1'b1, 0);
      n_tests++;
      if (o_flags !== 3'b010 || o_addr !== 11'h300 || o_map !== '0 || o_probes !== 3'd1 || o_lat != RDL + 3) begin
         n_fail++; $display("FAIL ins_home_result: got flags=%b addr=%h map=%h probes=%0d lat=%0d want 010/300/0/1/%0d",
                            o_flags, o_addr, o_map, o_probes, o_lat, RDL + 3);
      end
      n_tests++;
      if (wr_n - base_wr != 1 || wr_a_log[base_wr[9:0]] !== 11'h300 ||
          wr_d_log[base_wr[9:0]] !== 64'hFEED_0000_0000_0300 || ct_n != base_ct) begin
         n_fail++; $display("FAIL ins_home_write: got writes=%0d addr=%h data=%h ct_writes=%0d want 1/300/feed000000000300/0",
                            wr_n - base_wr, wr_a_log[base_wr[9:0]], wr_d_log[base_wr[9:0]], ct_n - base_ct);
      end
      mem_valid[11'h300] = 1'b1; mem_data[11'h300] = 64'hFEED_0000_0000_0300; mem_map[11'h300] = 11'h0AB;
   endtask

   task automatic test_wrap_insert;
      mem_valid[11'h7FF] = 1'b1; mem_data[11'h7FF] = 64'hDEAD; mem_map[11'h7FF] = 11'h055;
      mem_valid[11'h100] = 1'b0;
      do_req(11'h7FF, 64'hBEEF_0000_0000_07FF, 1'b1, 1'b0, 0);
      n_tests++;
      if (rd_n - base_rd != 2 || rd_log[base_rd[9:0]] !== 11'h7FF || rd_log[9'(base_rd + 1)] !== 11'h100) begin
         n_fail++; $display("FAIL wrap_reads: got reads=%0d first=%h second=%h want 2/7ff/100",
                            rd_n - base_rd, rd_log[base_rd[9:0]], rd_log[9'(base_rd + 1)]);
      end
      n_tests++;
      if (wr_n - base_wr != 1 || wr_a_log[base_wr[9:0]] !== 11'h100 || wr_d_log[base_wr[9:0]] !== 64'hBEEF_0000_0000_07FF) begin
         n_fail++; $display("FAIL wrap_write: got writes=%0d addr=%h want 1/100", wr_n - base_wr, wr_a_log[base_wr[9:0]]);
      end
      n_tests++;
      if (ct_n - base_ct != 1 || ct_log[base_ct[9:0]] !== 11'h100) begin
         n_fail++; $display("FAIL wrap_ct: got ct_writes=%0d ct_addr=%h want 1/100", ct_n - base_ct, ct_log[base_ct[9:0]]);
      end
      n_tests++;
      if (o_flags !== 3'b010 || o_addr !== 11'h100 || o_probes !== 3'd2 || o_lat != 2 * (RDL + 1) + 2) begin
         n_fail++; $display("FAIL wrap_result: got flags=%b addr=%h probes=%0d lat=%0d want 010/100/2/%0d",
                            o_flags, o_addr, o_probes, o_lat, 2 * (RDL + 1) + 2);
      end
      mem_valid[11'h100] = 1'b1; mem_data[11'h100] = 64'hBEEF_0000_0000_07FF; mem_map[11'h100] = 11'h066;
   endtask

   task automatic test_probe_limit;
      for (int i = 0; i < 5; i++) begin
         mem_valid[11'h400 + 11'(i)] = 1'b1;
         mem_data[11'h400 + 11'(i)]  = 64'h1000 + 64'(i);
         mem_map[11'h400 + 11'(i)]   = 11'(i);
      end
      do_req(11'h400, 64'h5555, 1'b1, 1'b0, 0);
      n_tests++;
      if (o_flags !== 3'b001 || o_addr !== 11'h400 || o_map !== '0 || o_probes !== 3'(MAXP) ||
          o_lat != MAXP * (RDL + 1) + 1) begin
         n_fail++; $display("FAIL limit_result: got flags=%b addr=%h map=%h probes=%0d lat=%0d want 001/400/0/%0d/%0d",
                            o_flags, o_addr, o_map, o_probes, o_lat, MAXP, MAXP * (RDL + 1) + 1);
      end
      n_tests++;
      if (wr_n != base_wr || ct_n != base_ct || rd_n - base_rd != MAXP) begin
         n_fail++; $display("FAIL limit_traffic: got reads=%0d writes=%0d ct=%0d want %0d/0/0",
                            rd_n - base_rd, wr_n - base_wr, ct_n - base_ct, MAXP);
      end
      mem_valid[11'h401] = 1'b0;
      do_req(11'h400, 64'h5555, 1'b1, 1'b1, 0);
      n_tests++;
      if (o_flags !== 3'b001 || o_probes !== 3'd2 || wr_n != base_wr || ct_n != base_ct) begin
         n_fail++; $display("FAIL ctfull: got flags=%b probes=%0d writes=%0d ct=%0d want 001/2/0/0",
                            o_flags, o_probes, wr_n - base_wr, ct_n - base_ct);
      end
      do_req(11'h400, 64'h5555, 1'b0, 1'b1, 0);
      n_tests++;
      if (o_flags !== 3'b000 || o_addr !== 11'h401 || o_probes !== 3'd2 || wr_n != base_wr) begin
         n_fail++; $display("FAIL miss_free: got flags=%b addr=%h probes=%0d writes=%0d want 000/401/2/0",
                            o_flags, o_addr, o_probes, wr_n - base_wr);
      end
   endtask

   task automatic test_backpressure;
      do_req(11'h300, 64'hFEED_0000_0000_0300, 1'b0, 1'b0, 5);
      n_tests++;
      if (o_unstable != 0 || o_flags !== 3'b100 || o_map !== 11'h0AB) begin
         n_fail++; $display("FAIL backpressure: got unstable_cycles=%0d flags=%b map=%h want 0/100/0ab",
                            o_unstable, o_flags, o_map);
      end
      n_tests++;
      if (o_after !== 2'b01) begin
         n_fail++; $display("FAIL release: got rsp_valid,req_ready=%b want 01", o_after);
      end
   endtask

   task automatic test_reset_mid;
      int bad;
      bad = 0;
      mem_valid[11'h500] = 1'b0;
      @(negedge clk);
      base_wr = wr_n; base_ct = ct_n;
      bus.req_valid = 1'b1; bus.req_hash = 11'h500; bus.req_str = 64'h7777; bus.req_insert = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      n_tests++;
      if (bus.ram_cs !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 11'h500) begin
         n_fail++; $display("FAIL mid_issue: got cs=%b we=%b addr=%h want 1/0/500", bus.ram_cs, bus.ram_we, bus.ram_addr);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if ({bus.req_ready, bus.rsp_valid, bus.ram_cs, bus.ram_we, bus.ct_we} !== 5'b10000 ||
          {bus.rsp_addr, bus.ram_addr, bus.ram_wdata} !== '0) begin
         n_fail++; $display("FAIL mid_reset_idle: got ready=%b valid=%b cs=%b we=%b ct_we=%b want 1/0/0/0/0",
                            bus.req_ready, bus.rsp_valid, bus.ram_cs, bus.ram_we, bus.ct_we);
      end
      repeat (8) begin
         @(negedge clk);
         if (bus.ram_we || bus.ct_we || bus.rsp_valid || !bus.req_ready) bad++;
      end
      n_tests++;
      if (bad != 0 || wr_n != base_wr || ct_n != base_ct) begin
         n_fail++; $display("FAIL mid_reset_quiet: got bad_cycles=%0d writes=%0d ct=%0d want 0/0/0",
                            bad, wr_n - base_wr, ct_n - base_ct);
      end
   endtask

   task automatic test_random;
      logic [DW-1:0] pool [4];
      logic [HW-1:0] h;
      logic [DW-1:0] s;
      logic          ins, ctf;
      int            bad, r, idx;
      pool[0] = 64'h1111_AAAA; pool[1] = 64'h2222_BBBB; pool[2] = 64'h3333_CCCC; pool[3] = 64'h4444_DDDD;
      for (int i = 0; i < 4; i++) begin
         mem_valid[11'h7FC + 11'(i)] = ($urandom_range(0, 1) == 1);
         mem_data[11'h7FC + 11'(i)]  = pool[$urandom_range(0, 3)];
         mem_map[11'h7FC + 11'(i)]   = 11'($urandom);
      end
      for (int i = 0; i < 6; i++) begin
         mem_valid[11'h100 + 11'(i)] = ($urandom_range(0, 2) == 0);
         mem_data[11'h100 + 11'(i)]  = pool[$urandom_range(0, 3)];
         mem_map[11'h100 + 11'(i)]   = 11'($urandom);
      end
      for (int it = 0; it < 40; it++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      h = 11'($urandom_range(0, MINA - 1));
         else if (r < 5)  h = 11'h7FC + 11'($urandom_range(0, 3));
         else             h = 11'h100 + 11'($urandom_range(0, 5));
         s   = pool[$urandom_range(0, 3)];
         ins = ($urandom_range(0, 2) != 0);
         ctf = ($urandom_range(0, 3) == 0);
         model(h, s, ins, ctf);
         do_req(h, s, ins, ctf, int'($urandom_range(0, 2)));
         n_tests++;
         if (o_timeout !== 1'b0 || o_ready0 !== 1'b1 || o_flags !== e_flags) begin
            n_fail++; $display("FAIL rnd%0d_flags: hash=%h got timeout=%b ready=%b flags=%b want 0/1/%b",
                               it, h, o_timeout, o_ready0, o_flags, e_flags);
         end
         n_tests++;
         if ((e_addr_chk && o_addr !== e_addr) || o_map !== e_map || int'(o_probes) != e_probes || o_lat != e_lat) begin
            n_fail++; $display("FAIL rnd%0d_result: got addr=%h map=%h probes=%0d lat=%0d want %h/%h/%0d/%0d",
                               it, o_addr, o_map, o_probes, o_lat, e_addr, e_map, e_probes, e_lat);
         end
         bad = 0;
         if (rd_n - base_rd != e_probes) bad++;
         for (int k = 0; k < e_probes && k < rd_n - base_rd; k++) begin
            idx = base_rd + k;
            if (rd_log[idx[9:0]] !== e_rd[k]) bad++;
         end
         if (wr_n - base_wr != (e_flags[1] ? 1 : 0)) bad++;
         else if (e_flags[1] && (wr_a_log[base_wr[9:0]] !== e_addr || wr_d_log[base_wr[9:0]] !== s)) bad++;
         if (ct_n - base_ct != (e_ct ? 1 : 0)) bad++;
         else if (e_ct && ct_log[base_ct[9:0]] !== e_addr) bad++;
         if (o_unstable != 0 || o_after !== 2'b01) bad++;
         n_tests++;
         if (bad != 0) begin
            n_fail++; $display("FAIL rnd%0d_traffic: hash=%h got %0d discrepancies (reads=%0d writes=%0d ct=%0d) want 0 (reads=%0d writes=%0d ct=%0d)",
                               it, h, bad, rd_n - base_rd, wr_n - base_wr, ct_n - base_ct,
                               e_probes, e_flags[1] ? 1 : 0, e_ct ? 1 : 0);
         end
         if (e_flags[1]) begin
            mem_valid[e_addr] = 1'b1;
            mem_data[e_addr]  = s;
            mem_map[e_addr]   = e_addr ^ 11'h155;
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      bus.req_valid = 1'b0; bus.req_hash = '0; bus.req_str = '0; bus.req_insert = 1'b0;
      bus.rsp_ready = 1'b0; bus.ct_full = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         mem_valid[i] = 1'b0;
         mem_data[i]  = '0;
         mem_map[i]   = '0;
      end
      test_reset;
      test_direct;
      test_hit;
      test_insert_home;
      test_wrap_insert;
      test_probe_limit;
      test_backpressure;
      test_reset_mid;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "time limit");
   end
endmodule
